// File: rtl/sa_seq_ctrl.sv
// Sequencer for an N x N systolic array: weight load, skewed input stream,
// flush/drain of results, and WS/OS dataflow selection.
module sa_seq_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             preload,
    output logic             switch,
    output logic             w_en,
    output logic [IDX_W-1:0] w_row,
    output logic [N-1:0]     in_en,
    output logic [CNT_W:0]   in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    localparam int CW = CNT_W + 1;
    localparam int EW = CNT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             switch_q, switch_d;

    logic [EW-1:0] cnt_x;
    logic [EW-1:0] stream_last;
    logic          phase_last;

    // Widened so the stream end compare cannot wrap for len = 2^CNT_W-1
    assign cnt_x       = EW'(cnt_q);
    assign stream_last = EW'(len_q) + EW'(N) - EW'(2);
    assign phase_last  = (cnt_x == EW'(N - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        len_d    = len_q;
        switch_d = switch_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && (len != '0)) begin
                    switch_d = mode;
                    len_d    = len;
                    state_d  = mode ? S_STREAM : S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (phase_last) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                end
            end
            S_STREAM: begin
                if (cnt_x == stream_last) begin
                    state_d = switch_q ? S_DRAIN : S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH, S_DRAIN: begin
                if (phase_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            len_d    = len_q;
            switch_d = switch_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            switch_q <= switch_d;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        preload   = 1'b0;
        switch    = switch_q;
        w_en      = 1'b0;
        w_row     = '0;
        in_en     = '0;
        in_idx    = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        unique case (state_q)
            S_WLOAD: begin
                w_en  = 1'b1;
                w_row = cnt_q[IDX_W-1:0];
            end
            S_STREAM: begin
                preload = 1'b1;
                in_idx  = cnt_q;
                // Row r sees vectors t = r .. r+len-1 (diagonal skew)
                for (int r = 0; r < N; r++) begin
                    in_en[r] = (cnt_x >= EW'(r)) &&
                               (cnt_x <= EW'(r) + EW'(len_q) - EW'(1));
                end
            end
            S_FLUSH: begin
                preload   = 1'b1;
                out_valid = 1'b1;
                out_idx   = cnt_q[IDX_W-1:0];
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_idx   = cnt_q[IDX_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl: per-cycle expected output vectors are
// queued when an operation is launched and compared each cycle.
module tb_sa_seq_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       preload;
        logic       sw;
        logic       w_en;
        logic [1:0] w_row;
        logic [3:0] in_en;
        logic [8:0] in_idx;
        logic       out_valid;
        logic [1:0] out_idx;
    } vec_t;

    logic       clk;
    logic       nrst;
    logic       start;
    logic       mode;
    logic [7:0] len;
    logic       abort;
    logic       busy;
    logic       done;
    logic       preload;
    logic       switch_o;
    logic       w_en;
    logic [1:0] w_row;
    logic [3:0] in_en;
    logic [8:0] in_idx;
    logic       out_valid;
    logic [1:0] out_idx;

    vec_t  exp_q[$];
    logic  idle_sw;
    int    n_vec;
    int    n_bad;
    int    cyc;
    string tag;

    sa_seq_ctrl #(.N(4), .CNT_W(8), .IDX_W(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .preload   (preload),
        .switch    (switch_o),
        .w_en      (w_en),
        .w_row     (w_row),
        .in_en     (in_en),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t idle_vec(input logic sw);
        vec_t v;
        v    = '0;
        v.sw = sw;
        return v;
    endfunction

    task automatic check(input vec_t e);
        vec_t g;
        g = '{busy, done, preload, switch_o, w_en, w_row,
              in_en, in_idx, out_valid, out_idx};
        n_vec++;
        assert (g === e) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, g, e);
        end
    endtask

    task automatic step();
        vec_t e;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = idle_vec(idle_sw);
        check(e);
    endtask

    // Expected trace built from the documented phase timing
    task automatic push_op(input logic m, input int l);
        vec_t v;
        if (!m) begin
            for (int i = 0; i < 4; i++) begin
                v       = '0;
                v.busy  = 1'b1;
                v.w_en  = 1'b1;
                v.w_row = 2'(i);
                exp_q.push_back(v);
            end
        end
        for (int t = 0; t < l + 3; t++) begin
            v         = '0;
            v.busy    = 1'b1;
            v.sw      = m;
            v.preload = 1'b1;
            v.in_idx  = 9'(t);
            for (int r = 0; r < 4; r++)
                v.in_en[r] = (t >= r) && (t <= r + l - 1);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 4; i++) begin
            v           = '0;
            v.busy      = 1'b1;
            v.sw        = m;
            v.preload   = !m;
            v.out_valid = 1'b1;
            v.out_idx   = 2'(i);
            exp_q.push_back(v);
        end
        v      = '0;
        v.busy = 1'b1;
        v.done = 1'b1;
        v.sw   = m;
        exp_q.push_back(v);
        idle_sw = m;
    endtask

    task automatic launch(input logic m, input int l);
        start = 1'b1;
        mode  = m;
        len   = 8'(l);
        if (l != 0) push_op(m, l);
    endtask

    task automatic drain_q();
        while (exp_q.size() > 0) step();
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        cyc     = 0;
        idle_sw = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        mode    = 1'b0;
        len     = '0;
        nrst    = 1'b0;
        tag     = "reset";
        #12;
        check(idle_vec(1'b0));
        nrst = 1'b1;
        step();

        tag = "ws_len3";
        launch(1'b0, 3);
        drain_q();
        step();

        tag = "os_len2";
        launch(1'b1, 2);
        drain_q();
        step();

        tag = "len0";
        launch(1'b0, 0);
        step();
        step();

        tag = "start_busy";
        launch(1'b0, 3);
        step();
        step();
        step();
        start = 1'b1;
        mode  = 1'b1;
        len   = 8'd7;
        drain_q();
        step();

        tag = "abort";
        launch(1'b0, 3);
        for (int i = 0; i < 6; i++) step();
        abort = 1'b1;
        exp_q.delete();
        step();
        step();
        tag = "after_abort_os";
        launch(1'b1, 3);
        drain_q();
        step();

        tag = "abort_vs_start";
        launch(1'b0, 2);
        abort = 1'b1;
        exp_q.delete();
        idle_sw = 1'b1;
        step();
        step();

        tag = "len255";
        launch(1'b0, 255);
        drain_q();
        step();

        tag = "b2b_first";
        launch(1'b1, 3);
        drain_q();
        step();
        tag = "b2b_second";
        launch(1'b0, 2);
        drain_q();
        step();

        tag = "async_reset";
        launch(1'b0, 5);
        for (int i = 0; i < 7; i++) step();
        #2;
        nrst = 1'b0;
        #1;
        exp_q.delete();
        idle_sw = 1'b0;
        check(idle_vec(1'b0));
        #2;
        nrst = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
